echo_request_arbiter: RTL and testbench

- Shares the single EchoRequest pipe (128-bit packed message, method id in bits [31:16]) between NUM_REQ requesters.
- Each requester has a one-entry holding buffer. A round-robin scheduler forwards one buffered message per cycle to the downstream method demultiplexer.
- Bits [15:0] of each forwarded message are overwritten with the source index, so replies can be routed back to the requester.

---
 rtl/echo_request_arbiter_pkg.sv | 19 +
 rtl/echo_request_arbiter_rr_arbiter.sv | 45 ++++
 rtl/echo_request_arbiter.sv | 112 +++++++++++
 tb/tb_echo_request_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/echo_request_arbiter_pkg.sv
// Shared EchoRequest message layout constants and header type for the request arbiter.
package echo_request_arbiter_pkg;

    localparam int ECHO_MSG_WIDTH     = 128;
    localparam int ECHO_METHOD_ID_LSB = 16;
    localparam int ECHO_METHOD_ID_MSB = 31;
    localparam int ECHO_SRC_TAG_MSB   = 15;

    localparam logic [15:0] ECHO_METHOD_SAY2    = 16'd0;
    localparam logic [15:0] ECHO_METHOD_SAY     = 16'd1;
    localparam logic [15:0] ECHO_METHOD_SETLEDS = 16'd2;

    // Low 32 bits of every message: method id above, source tag below.
    typedef struct packed {
        logic [15:0] method_id;
        logic [15:0] src_tag;
    } echo_hdr_t;

endpackage

// File: rtl/echo_request_arbiter_rr_arbiter.sv
// Round-robin grant: first set request at or above ptr (mod NUM_REQ), plus the pointer after an advance.
module echo_request_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any_req,
    output logic [IDX_W-1:0]   next_ptr
);

    int cand;

    // Scanning from the far end lets the last hit be the one closest to ptr.
    always_comb begin
        cand    = 0;
        gnt_idx = '0;
        any_req = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (req[cand]) begin
                gnt_idx = IDX_W'(cand);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_onehot[i] = any_req && (gnt_idx == IDX_W'(i));
        end
    end

    always_comb begin
        next_ptr = ptr;
        if (advance) begin
            next_ptr = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/echo_request_arbiter.sv
// Shares one EchoRequest pipe among NUM_REQ one-entry requester buffers, tagging [15:0] with the source.
// Optional per-requester grant counters are built when ECHO_ARB_STATS_EN is defined.
module echo_request_arbiter
    import echo_request_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = ECHO_MSG_WIDTH,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic [NUM_REQ-1:0]            req_enq__ENA,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_enq_v,
    output logic [NUM_REQ-1:0]            req_enq__RDY,
    output logic                          pipe_enq__ENA,
    output logic [DATA_WIDTH-1:0]         pipe_enq_v,
    input  logic                          pipe_enq__RDY
`ifdef ECHO_ARB_STATS_EN
    ,
    input  logic                          stats_clear__ENA,
    output logic [NUM_REQ*16-1:0]         stats_grant_count
`endif
);

    logic [NUM_REQ-1:0]    valid_q;
    logic [NUM_REQ-1:0]    gnt_onehot;
    logic [NUM_REQ-1:0]    deq;
    logic [IDX_W-1:0]      rr_ptr_q;
    logic [IDX_W-1:0]      rr_ptr_nxt;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  any_valid;
    logic [DATA_WIDTH-1:0] msg_buf [NUM_REQ];
    logic [DATA_WIDTH-1:0] sel_msg;
    echo_hdr_t             out_hdr;

    echo_request_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req        (valid_q),
        .ptr        (rr_ptr_q),
        .advance    (pipe_enq__ENA),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any_req    (any_valid),
        .next_ptr   (rr_ptr_nxt)
    );

    assign pipe_enq__ENA = any_valid & pipe_enq__RDY;
    assign deq           = gnt_onehot & {NUM_REQ{pipe_enq__ENA}};
    // A buffer being drained this cycle can accept its replacement on the same edge.
    assign req_enq__RDY  = ~valid_q | deq;

    assign sel_msg           = msg_buf[gnt_idx];
    assign out_hdr.method_id = sel_msg[ECHO_METHOD_ID_MSB:ECHO_METHOD_ID_LSB];
    assign out_hdr.src_tag   = 16'(gnt_idx);

    always_comb begin
        pipe_enq_v       = sel_msg;
        pipe_enq_v[31:0] = out_hdr;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            valid_q  <= (valid_q & ~deq) | req_enq__ENA;
            rr_ptr_q <= rr_ptr_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_enq__ENA[i]) begin
                msg_buf[i] <= req_enq_v[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef ECHO_ARB_STATS_EN
    logic [15:0] grant_cnt_q [NUM_REQ];

    // Clear takes priority over a same-cycle grant; counters stick at all-ones.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (stats_clear__ENA) begin
                    grant_cnt_q[i] <= '0;
                end else if (deq[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        assign stats_grant_count[g*16 +: 16] = grant_cnt_q[g];
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
        if (nRST) begin
            assert ((req_enq__ENA & ~req_enq__RDY) == '0);
        end
    end
`endif

endmodule

// File: tb/tb_echo_request_arbiter.sv
// Randomized bench for echo_request_arbiter against a queue-level reference model of the buffers.
// Exercises the grant counters as well when ECHO_ARB_STATS_EN is defined.
module tb_echo_request_arbiter;
    import echo_request_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int DW = 128;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_ena;
    logic [N*DW-1:0] req_v;
    logic [N-1:0]    req_rdy;
    logic            pipe_ena;
    logic [DW-1:0]   pipe_v;
    logic            pipe_rdy;
`ifdef ECHO_ARB_STATS_EN
    logic            stats_clear;
    logic [N*16-1:0] stats_cnt;
`endif

    always #5 clk = ~clk;

    echo_request_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW)
    ) dut (
        .CLK           (clk),
        .nRST          (rst_n),
        .req_enq__ENA  (req_ena),
        .req_enq_v     (req_v),
        .req_enq__RDY  (req_rdy),
        .pipe_enq__ENA (pipe_ena),
        .pipe_enq_v    (pipe_v),
        .pipe_enq__RDY (pipe_rdy)
`ifdef ECHO_ARB_STATS_EN
        ,
        .stats_clear__ENA  (stats_clear),
        .stats_grant_count (stats_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one slot per requester, a next-in-line pointer, grant tallies.
    logic          m_valid [N];
    logic [DW-1:0] m_msg   [N];
    int            m_ptr;
    logic [15:0]   m_cnt   [N];
    logic [DW-1:0] exp_q[$];

    logic          last_ena;
    logic [DW-1:0] last_v;
    logic [N-1:0]  last_rdy;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int model_gnt();
        for (int k = 0; k < N; k++) begin
            if (m_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] model_out(input int g);
        logic [DW-1:0] m;
        m = m_msg[g];
        m[15:0] = 16'(g);
        return m;
    endfunction

    function automatic logic [N*DW-1:0] rand_msgs();
        logic [N*DW-1:0] r;
        for (int w = 0; w < N * DW / 32; w++) r[w*32 +: 32] = $urandom();
        for (int i = 0; i < N; i++) r[i*DW + 16 +: 16] = 16'($urandom_range(0, 2));
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_msg[i]   = '0;
            m_cnt[i]   = '0;
        end
        m_ptr = 0;
        exp_q.delete();
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive_cycle(input logic [N-1:0] want, input logic prdy,
                               input logic [N*DW-1:0] msgs, input logic clr);
        int           g;
        logic         m_ena;
        logic [N-1:0] m_rdy;
        logic [N-1:0] enq;
        logic [N*16-1:0] cnt_exp;
        g     = model_gnt();
        m_ena = (g >= 0) && prdy;
        for (int i = 0; i < N; i++) m_rdy[i] = !m_valid[i] || (m_ena && g == i);
        enq      = want & m_rdy;
        pipe_rdy = prdy;
        req_ena  = enq;
        req_v    = msgs;
`ifdef ECHO_ARB_STATS_EN
        stats_clear = clr;
`endif
        #1;
        last_ena = pipe_ena;
        last_v   = pipe_v;
        last_rdy = req_rdy;
        check("pipe_ena", 128'(pipe_ena), 128'(m_ena));
        check("req_rdy", 128'(req_rdy), 128'(m_rdy));
        check("out_known", 128'($isunknown({pipe_ena, req_rdy})), 128'(1'b0));
        if (g >= 0 && !m_ena) check("held_v", pipe_v, model_out(g));
        if (m_ena) exp_q.push_back(model_out(g));
        if (pipe_ena && exp_q.size() > 0) check("fwd_msg", pipe_v, exp_q.pop_front());
        exp_q.delete();
        @(posedge clk);
        if (m_ena) begin
            m_valid[g] = 1'b0;
            m_ptr      = (g + 1) % N;
            if (m_cnt[g] != 16'hFFFF) m_cnt[g] = m_cnt[g] + 16'd1;
        end
        if (clr) for (int i = 0; i < N; i++) m_cnt[i] = '0;
        for (int i = 0; i < N; i++) begin
            if (enq[i]) begin
                m_valid[i] = 1'b1;
                m_msg[i]   = msgs[i*DW +: DW];
            end
        end
        #1;
        for (int i = 0; i < N; i++) cnt_exp[i*16 +: 16] = m_cnt[i];
`ifdef ECHO_ARB_STATS_EN
        check("grant_cnt", 128'(stats_cnt), 128'(cnt_exp));
`endif
        @(negedge clk);
    endtask

    initial begin
        logic [N*DW-1:0] msgs;

        rst_n    = 1'b0;
        req_ena  = '0;
        req_v    = '0;
        pipe_rdy = 1'b0;
`ifdef ECHO_ARB_STATS_EN
        stats_clear = 1'b0;
`endif
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset.
        for (int c = 0; c < 10; c++) drive_cycle(3'b000, 1'b1, rand_msgs(), 1'b0);

        // Single requester with a known message, then streaming.
        msgs = rand_msgs();
        msgs[DW + 63 -: 32] = 32'hDEADBEEF;
        msgs[DW + 31 -: 16] = ECHO_METHOD_SAY;
        drive_cycle(3'b010, 1'b1, msgs, 1'b0);
        drive_cycle(3'b010, 1'b1, rand_msgs(), 1'b0);
        check("single_ena", 128'(last_ena), 128'(1'b1));
        check("single_hdr", 128'(last_v[63:0]), {64'h0, 32'hDEADBEEF, 16'd1, 16'd1});
        for (int c = 0; c < 8; c++) begin
            drive_cycle(3'b010, 1'b1, rand_msgs(), 1'b0);
            check("stream_ena", 128'(last_ena), 128'(1'b1));
        end

        // Fill everything, then reset mid-cycle.
        drive_cycle(3'b111, 1'b0, rand_msgs(), 1'b0);
        #2;
        rst_n    = 1'b0;
        pipe_rdy = 1'b1;
        req_ena  = '0;
        #1;
        check("rst_ena", 128'(pipe_ena), 128'(1'b0));
        check("rst_rdy", 128'(req_rdy), 128'(3'b111));
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Backpressure with requesters 0 and 2 buffered.
        drive_cycle(3'b101, 1'b0, rand_msgs(), 1'b0);
        for (int c = 0; c < 5; c++) begin
            drive_cycle(3'b000, 1'b0, rand_msgs(), 1'b0);
            check("bp_ena", 128'(last_ena), 128'(1'b0));
            check("bp_rdy02", 128'({last_rdy[2], last_rdy[0]}), 128'(2'b00));
        end
        drive_cycle(3'b000, 1'b1, rand_msgs(), 1'b0);
        check("bp_rel_tag0", 128'(last_v[15:0]), 128'(16'd0));
        drive_cycle(3'b000, 1'b1, rand_msgs(), 1'b0);
        check("bp_rel_tag2", 128'(last_v[15:0]), 128'(16'd2));

        // Full contention from pointer 0.
        for (int c = 0; c < 7; c++) begin
            drive_cycle(3'b111, 1'b1, rand_msgs(), 1'b0);
            if (c >= 1) begin
                check("cont_ena", 128'(last_ena), 128'(1'b1));
                check("cont_tag", 128'(last_v[15:0]), 128'((c - 1) % 3));
            end
        end

        // Random traffic and backpressure.
        for (int c = 0; c < 2000; c++) begin
            drive_cycle(N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 3) != 0),
                        rand_msgs(), 1'b0);
        end

`ifdef ECHO_ARB_STATS_EN
        for (int c = 0; c < 70001; c++) drive_cycle(3'b001, 1'b1, rand_msgs(), 1'b0);
        check("cnt0_sat", 128'(stats_cnt[15:0]), 128'(16'hFFFF));
        drive_cycle(3'b000, 1'b1, rand_msgs(), 1'b1);
        check("cnt0_clear", 128'(stats_cnt[15:0]), 128'(16'h0000));
        drive_cycle(3'b000, 1'b1, rand_msgs(), 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
